// File: rtl/axi_stream_strip_header.sv
// -----------------------------------------------------------------------------
// axi_stream_strip_header
//
// Removes a per-packet programmable number of leading header bytes from an
// AXI-Stream packet and re-aligns the remaining payload to the MSB lane.
// The payload leaves on a registered output stream. The stripped header is
// reported on a side port.
//
// Optional feature macro: STRIP_HDR_OUT_EN
//   defined   -> hdr_vld / hdr_data / hdr_keep are driven by a capture register
//   undefined -> hdr_vld / hdr_data / hdr_keep are tied to 0
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   valid_in/ready_in             input beat handshake
//   data_in/keep_in/last_in       input beat (first byte in the MSB lane)
//   valid_out/ready_out           output beat handshake
//   data_out/keep_out/last_out    MSB-aligned payload beat (unkept lanes are 0)
//   valid_strip/ready_strip       per-packet strip command handshake
//   byte_strip_cnt                header length minus one
//   hdr_vld/hdr_data/hdr_keep     header capture pulse, right-aligned header
//   pkt_drop                      pulse: packet carried no payload bytes
// -----------------------------------------------------------------------------
module axi_stream_strip_header #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    valid_strip,
  output logic                    ready_strip,
  input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
  output logic                    hdr_vld,
  output logic [DATA_WD-1:0]      hdr_data,
  output logic [DATA_BYTE_WD-1:0] hdr_keep,
  output logic                    pkt_drop
);

  localparam int unsigned W      = DATA_BYTE_WD;
  localparam int unsigned LEN_WD = BYTE_CNT_WD + 1;
  localparam int unsigned SH_WD  = LEN_WD + 3;
  localparam logic [LEN_WD-1:0] FULL_LEN = LEN_WD'(W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_BODY,
    S_FLUSH
  } state_t;

  // Mask of the k most significant lanes.
  function automatic logic [W-1:0] top_lanes(input logic [LEN_WD-1:0] k);
    top_lanes = ~({W{1'b1}} >> k);
  endfunction

  // Mask of the k least significant lanes.
  function automatic logic [W-1:0] low_lanes(input logic [LEN_WD-1:0] k);
    low_lanes = ~({W{1'b1}} << k);
  endfunction

  // Expand a lane mask to a bit mask.
  function automatic logic [DATA_WD-1:0] lane_mask(input logic [W-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < W; i++) begin
      m[i*8 +: 8] = {8{k[i]}};
    end
    return m;
  endfunction

  // Number of enabled lanes.
  function automatic logic [LEN_WD-1:0] lane_count(input logic [W-1:0] k);
    logic [LEN_WD-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < W; i++) begin
      c = c + LEN_WD'(k[i]);
    end
    return c;
  endfunction

  // Byte count to bit shift amount.
  function automatic logic [SH_WD-1:0] bits_of(input logic [LEN_WD-1:0] k);
    return {k, 3'b000};
  endfunction

  state_t                state_q, state_n;
  logic [BYTE_CNT_WD-1:0] cnt_q, cnt_n;
  logic [DATA_WD-1:0]    residue_q, residue_n;
  logic [W-1:0]          flush_keep_q, flush_keep_n;

  logic                  valid_out_n, last_out_n, pkt_drop_n, ready_strip_n;
  logic [DATA_WD-1:0]    data_out_n;
  logic [W-1:0]          keep_out_n;

  logic [LEN_WD-1:0]     n_len, s_len, ws_len, in_len;
  logic [DATA_WD-1:0]    din_m;
  logic                  out_free, in_fire, strip_fire;

  // Header length N, split S = N mod W, residue width W-S, beat length L.
  assign n_len  = LEN_WD'(cnt_q) + LEN_WD'(1);
  assign s_len  = (n_len == FULL_LEN) ? '0 : n_len;
  assign ws_len = FULL_LEN - s_len;
  assign in_len = lane_count(keep_in);
  assign din_m  = data_in & lane_mask(keep_in);

  assign out_free   = !valid_out || ready_out;
  assign ready_in   = ((state_q == S_HDR) || (state_q == S_BODY)) && out_free;
  assign in_fire    = valid_in && ready_in;
  assign strip_fire = valid_strip && ready_strip;

  // Next-state and next-register values.
  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    residue_n    = residue_q;
    flush_keep_n = flush_keep_q;
    valid_out_n  = valid_out;
    data_out_n   = data_out;
    keep_out_n   = keep_out;
    last_out_n   = last_out;
    pkt_drop_n   = 1'b0;

    if (valid_out && ready_out) begin
      valid_out_n = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (strip_fire) begin
          cnt_n   = byte_strip_cnt;
          state_n = S_HDR;
        end
      end

      S_HDR: begin
        if (in_fire) begin
          if (last_in) begin
            state_n = S_IDLE;
            if (in_len > n_len) begin
              valid_out_n = 1'b1;
              data_out_n  = din_m << bits_of(n_len);
              keep_out_n  = top_lanes(in_len - n_len);
              last_out_n  = 1'b1;
            end else begin
              pkt_drop_n = 1'b1;
            end
          end else begin
            // Bytes below the header become the left-aligned residue.
            residue_n = din_m << bits_of(s_len);
            state_n   = S_BODY;
          end
        end
      end

      S_BODY: begin
        if (in_fire) begin
          valid_out_n = 1'b1;
          if (s_len == '0) begin
            data_out_n = din_m;
            keep_out_n = keep_in;
            last_out_n = last_in;
            if (last_in) begin
              state_n = S_IDLE;
            end
          end else begin
            data_out_n = residue_q | (din_m >> bits_of(ws_len));
            residue_n  = din_m << bits_of(s_len);
            keep_out_n = '1;
            last_out_n = 1'b0;
            if (last_in) begin
              if (in_len <= s_len) begin
                keep_out_n = top_lanes(ws_len + in_len);
                last_out_n = 1'b1;
                state_n    = S_IDLE;
              end else begin
                // Leftover bytes do not fit: emit them in a trailing beat.
                flush_keep_n = top_lanes(in_len - s_len);
                state_n      = S_FLUSH;
              end
            end
          end
        end
      end

      S_FLUSH: begin
        if (out_free) begin
          valid_out_n = 1'b1;
          data_out_n  = residue_q;
          keep_out_n  = flush_keep_q;
          last_out_n  = 1'b1;
          state_n     = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    ready_strip_n = (state_n == S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      residue_q    <= '0;
      flush_keep_q <= '0;
      valid_out    <= 1'b0;
      data_out     <= '0;
      keep_out     <= '0;
      last_out     <= 1'b0;
      pkt_drop     <= 1'b0;
      ready_strip  <= 1'b0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      residue_q    <= residue_n;
      flush_keep_q <= flush_keep_n;
      valid_out    <= valid_out_n;
      data_out     <= data_out_n;
      keep_out     <= keep_out_n;
      last_out     <= last_out_n;
      pkt_drop     <= pkt_drop_n;
      ready_strip  <= ready_strip_n;
    end
  end

`ifdef STRIP_HDR_OUT_EN
  logic              hdr_fire;
  logic [LEN_WD-1:0] hdr_len;

  // A short single-beat packet reports only the bytes it actually carried.
  assign hdr_fire = in_fire && (state_q == S_HDR);
  assign hdr_len  = (last_in && (in_len < n_len)) ? in_len : n_len;

  // Header capture register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_vld  <= 1'b0;
      hdr_data <= '0;
      hdr_keep <= '0;
    end else begin
      hdr_vld <= hdr_fire;
      if (hdr_fire) begin
        hdr_data <= din_m >> bits_of(FULL_LEN - hdr_len);
        hdr_keep <= low_lanes(hdr_len);
      end
    end
  end
`else
  assign hdr_vld  = 1'b0;
  assign hdr_data = '0;
  assign hdr_keep = '0;
`endif

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Testbench for axi_stream_strip_header: directed vector table, mid-packet
// reset sequence and randomized packets against a byte-level reference model.
module tb_axi_stream_strip_header;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        valid_out;
  logic        ready_out = 1'b1;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        valid_strip = 1'b0;
  logic        ready_strip;
  logic [1:0]  byte_strip_cnt = '0;
  logic        hdr_vld;
  logic [31:0] hdr_data;
  logic [3:0]  hdr_keep;
  logic        pkt_drop;

`ifdef STRIP_HDR_OUT_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  axi_stream_strip_header #(.DATA_WD(32)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .ready_in(ready_in),
    .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .valid_out(valid_out), .ready_out(ready_out),
    .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .valid_strip(valid_strip), .ready_strip(ready_strip),
    .byte_strip_cnt(byte_strip_cnt),
    .hdr_vld(hdr_vld), .hdr_data(hdr_data), .hdr_keep(hdr_keep),
    .pkt_drop(pkt_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic        v;
    logic        p;
    logic [31:0] d;
    logic [3:0]  k;
  } hev_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  hev_t  hgot_q[$];
  hev_t  hexp_q[$];

  bit rand_mode = 1'b0;

  // Output backpressure, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    ready_out = rand_mode ? ($urandom_range(0, 99) < 80) : 1'b1;
  end

  // Output monitor: collects transferred beats, header events, stall stability.
  logic  stall_prev = 1'b0;
  beat_t stall_beat = '0;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 64'(valid_out), 64'(1));
        check("stall_beat", 64'({data_out, keep_out, last_out}), 64'(stall_beat));
      end
      stall_prev = valid_out && !ready_out;
      stall_beat = {data_out, keep_out, last_out};
      if (valid_out && ready_out) got_q.push_back({data_out, keep_out, last_out});
      if (hdr_vld || pkt_drop) hgot_q.push_back({hdr_vld, pkt_drop, hdr_data, hdr_keep});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Drivers: called and returning at a falling edge.
  task automatic send_cmd(input logic [1:0] c);
    int t = 0;
    valid_strip    = 1'b1;
    byte_strip_cnt = c;
    while (!ready_strip && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) timeout_fail("send_cmd");
    @(negedge clk);
    valid_strip = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int t = 0;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    while (!ready_in && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) timeout_fail("send_beat");
    @(negedge clk);
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic drain(input int n);
    int t = 0;
    while ((got_q.size() < n || valid_out) && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) timeout_fail("drain");
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]       cnt;
    int               nb;
    logic [2:0][31:0] d;
    logic [2:0][3:0]  k;
    int               no;
    logic [2:0][31:0] od;
    logic [2:0][3:0]  ok;
    logic [31:0]      hd;
    logic [3:0]       hk;
    logic             drop;
  } vec_t;

  vec_t vecs[7];

  task automatic apply_vec(input int i);
    vec_t v;
    int   ne;
    v = vecs[i];
    got_q.delete();
    hgot_q.delete();
    send_cmd(v.cnt);
    for (int b = 0; b < v.nb; b++) send_beat(v.d[b], v.k[b], b == v.nb - 1);
    drain(v.no);
    check($sformatf("vec%0d_nbeats", i), 64'(got_q.size()), 64'(v.no));
    for (int j = 0; j < v.no && j < got_q.size(); j++) begin
      check($sformatf("vec%0d_data%0d", i, j), 64'(got_q[j].d), 64'(v.od[j]));
      check($sformatf("vec%0d_keep%0d", i, j), 64'(got_q[j].k), 64'(v.ok[j]));
      check($sformatf("vec%0d_last%0d", i, j), 64'(got_q[j].l), 64'(j == v.no - 1));
    end
    ne = (HDR_EN || v.drop) ? 1 : 0;
    check($sformatf("vec%0d_hdr_events", i), 64'(hgot_q.size()), 64'(ne));
    if (hgot_q.size() > 0 && ne > 0) begin
      check($sformatf("vec%0d_drop", i), 64'(hgot_q[0].p), 64'(v.drop));
      check($sformatf("vec%0d_hdr_vld", i), 64'(hgot_q[0].v), 64'(HDR_EN));
      check($sformatf("vec%0d_hdr_data", i), 64'(hgot_q[0].d), 64'(HDR_EN ? v.hd : 32'h0));
      check($sformatf("vec%0d_hdr_keep", i), 64'(hgot_q[0].k), 64'(HDR_EN ? v.hk : 4'h0));
    end
    got_q.delete();
    hgot_q.delete();
  endtask

  // Random packet: the model strips the first N bytes and re-chunks the rest.
  task automatic rand_pkt();
    logic [1:0]   c;
    int           n, len, nb, h;
    byte unsigned bytes[$];
    beat_t        bt;
    hev_t         he;
    logic [31:0]  hd, d;
    logic [3:0]   hk, k;
    c   = 2'($urandom_range(0, 3));
    n   = int'(c) + 1;
    len = $urandom_range(1, 16);
    for (int i = 0; i < len; i++) bytes.push_back(8'($urandom));

    for (int p = n; p < len; p += 4) begin
      bt = '0;
      for (int q = 0; q < 4 && p + q < len; q++) begin
        bt.d[31-8*q -: 8] = bytes[p+q];
        bt.k[3-q]         = 1'b1;
      end
      bt.l = (p + 4 >= len);
      exp_q.push_back(bt);
    end
    h  = (len < n) ? len : n;
    hd = '0;
    for (int i = 0; i < h; i++) hd = (hd << 8) | 32'(bytes[i]);
    hk = 4'((1 << h) - 1);
    if (HDR_EN || len <= n) begin
      he.v = HDR_EN;
      he.p = (len <= n);
      he.d = HDR_EN ? hd : 32'h0;
      he.k = HDR_EN ? hk : 4'h0;
      hexp_q.push_back(he);
    end

    send_cmd(c);
    nb = (len + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      d = $urandom;
      k = '0;
      for (int q = 0; q < 4; q++) begin
        if (4 * b + q < len) begin
          d[31-8*q -: 8] = bytes[4*b+q];
          k[3-q]         = 1'b1;
        end
      end
      send_beat(d, k, b == nb - 1);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  initial begin
    vecs[0] = '{2'd1, 3, {32'h55660000, 32'h11223344, 32'hAABBCCDD}, {4'hC, 4'hF, 4'hF},
                2, {32'h0, 32'h33445566, 32'hCCDD1122}, {4'h0, 4'hF, 4'hF}, 32'h0000AABB, 4'h3, 1'b0};
    vecs[1] = '{2'd1, 3, {32'h55667700, 32'h11223344, 32'hAABBCCDD}, {4'hE, 4'hF, 4'hF},
                3, {32'h77000000, 32'h33445566, 32'hCCDD1122}, {4'h8, 4'hF, 4'hF}, 32'h0000AABB, 4'h3, 1'b0};
    vecs[2] = '{2'd3, 2, {32'h0, 32'h05060708, 32'h01020304}, {4'h0, 4'h8, 4'hF},
                1, {32'h0, 32'h0, 32'h05000000}, {4'h0, 4'h0, 4'h8}, 32'h01020304, 4'hF, 1'b0};
    vecs[3] = '{2'd3, 1, {32'h0, 32'h0, 32'hDEADBEEF}, {4'h0, 4'h0, 4'hF},
                0, {32'h0, 32'h0, 32'h0}, {4'h0, 4'h0, 4'h0}, 32'hDEADBEEF, 4'hF, 1'b1};
    vecs[4] = '{2'd0, 1, {32'h0, 32'h0, 32'h12345678}, {4'h0, 4'h0, 4'hF},
                1, {32'h0, 32'h0, 32'h34567800}, {4'h0, 4'h0, 4'hE}, 32'h00000012, 4'h1, 1'b0};
    vecs[5] = '{2'd2, 1, {32'h0, 32'h0, 32'hABCD0000}, {4'h0, 4'h0, 4'hC},
                0, {32'h0, 32'h0, 32'h0}, {4'h0, 4'h0, 4'h0}, 32'h0000ABCD, 4'h3, 1'b1};
    vecs[6] = '{2'd0, 2, {32'h0, 32'h55667788, 32'h11223344}, {4'h0, 4'hF, 4'hF},
                2, {32'h0, 32'h66778800, 32'h22334455}, {4'h0, 4'hE, 4'hF}, 32'h00000011, 4'h1, 1'b0};

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_ready_in", 64'(ready_in), 64'(0));
    check("rst_ready_strip", 64'(ready_strip), 64'(0));
    check("rst_valid_out", 64'(valid_out), 64'(0));
    check("rst_data_out", 64'(data_out), 64'(0));
    check("rst_keep_out", 64'(keep_out), 64'(0));
    check("rst_last_out", 64'(last_out), 64'(0));
    check("rst_hdr_vld", 64'(hdr_vld), 64'(0));
    check("rst_hdr_data", 64'(hdr_data), 64'(0));
    check("rst_hdr_keep", 64'(hdr_keep), 64'(0));
    check("rst_pkt_drop", 64'(pkt_drop), 64'(0));
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("ready_strip_before_edge", 64'(ready_strip), 64'(0));
    @(negedge clk);
    check("ready_strip_after_edge", 64'(ready_strip), 64'(1));
    check("ready_in_idle", 64'(ready_in), 64'(0));

    for (int i = 0; i < 7; i++) apply_vec(i);

    // Reset while a packet is in BODY with a beat held in the output register.
    send_cmd(2'd1);
    send_beat(32'hAABBCCDD, 4'hF, 1'b0);
    send_beat(32'h11223344, 4'hF, 1'b0);
    check("midrst_pre_valid", 64'(valid_out), 64'(1));
    check("midrst_pre_data", 64'(data_out), 64'(32'hCCDD1122));
    #2 rst = 1'b1;
    #1;
    check("midrst_valid_out", 64'(valid_out), 64'(0));
    check("midrst_data_out", 64'(data_out), 64'(0));
    check("midrst_keep_out", 64'(keep_out), 64'(0));
    check("midrst_last_out", 64'(last_out), 64'(0));
    check("midrst_ready_in", 64'(ready_in), 64'(0));
    check("midrst_ready_strip", 64'(ready_strip), 64'(0));
    check("midrst_hdr", 64'({hdr_vld, hdr_data, hdr_keep, pkt_drop}), 64'(0));
    @(posedge clk);
    #2 rst = 1'b0;
    got_q.delete();
    hgot_q.delete();
    @(negedge clk);
    apply_vec(0);

    // Randomized packets under random backpressure.
    rand_mode = 1'b1;
    repeat (100) rand_pkt();
    drain(exp_q.size());
    rand_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("rand_nbeats", 64'(got_q.size()), 64'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
      check($sformatf("rand_beat%0d", j), 64'(got_q[j]), 64'(exp_q[j]));
    check("rand_hdr_events", 64'(hgot_q.size()), 64'(hexp_q.size()));
    for (int j = 0; j < hexp_q.size() && j < hgot_q.size(); j++)
      check($sformatf("rand_hdr%0d", j), 64'(hgot_q[j]), 64'(hexp_q[j]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_stream_strip_header.md
# axi_stream_strip_header

Receive-side counterpart of the header-insertion block. It takes an AXI-Stream packet whose first bytes are a header, removes a per-packet programmable number of header bytes, and re-aligns the remaining payload to the MSB lane. It forwards the payload on a registered output stream and reports the stripped header on a side port. It sits at the ingress of the packet path, before payload consumers that expect header-free, MSB-aligned packets.

## Interface
- DATA_WD, 32, stream data width in bits; must be a multiple of 8.
- DATA_BYTE_WD, DATA_WD/8, number of byte lanes (W).
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of the strip count.

Ports (clk first; the one clock, reset asynchronous and active-high):
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- valid_in / ready_in  in / out  1 / 1  input beat handshake.
- data_in  in  DATA_WD  input data; first stream byte in data_in[DATA_WD-1 -: 8].
- keep_in  in  DATA_BYTE_WD  byte enables; all ones except on the last beat, which is MSB-contiguous (1000, 1100, 1110, 1111).
- last_in  in  1  last beat of the packet.
- valid_out / ready_out  out / in  1 / 1  output beat handshake.
- data_out  out  DATA_WD  payload, MSB-aligned; lanes with keep 0 are driven 0.
- keep_out  out  DATA_BYTE_WD  MSB-contiguous byte enables.
- last_out  out  1  last payload beat.
- valid_strip / ready_strip  in / out  1 / 1  per-packet strip command handshake.
- byte_strip_cnt  in  BYTE_CNT_WD  header length N = byte_strip_cnt+1 (range 1..W).
- hdr_vld  out  1  one-cycle pulse: header captured.
- hdr_data  out  DATA_WD  header bytes, right-aligned (LSB lanes).
- hdr_keep  out  DATA_BYTE_WD  LSB-contiguous mask of the header bytes received.
- pkt_drop  out  1  one-cycle pulse: the packet carried zero payload bytes.

## Operation
- S = N mod W. Exactly one strip command is consumed per packet.
- States:
  - IDLE: ready_strip=1, ready_in=0. A command is captured on valid_strip&ready_strip; go to HDR.
  - HDR: waits for the first beat. The header bytes (top N lanes) go to hdr_data/hdr_keep. If S>0, the low W-S lanes go to the residue register. Go to BODY, or handle last_in as below.
  - BODY:
    - S=0: beat j passes through unchanged.
    - S>0: output = {residue (W-S bytes), top S bytes of the new beat}; the low W-S bytes become the new residue.
  - FLUSH: emits the residue as a final beat, keep = top L-S lanes, then returns to IDLE.
- Last beat with L valid bytes (BODY, S>0):
  - L<=S: the merged beat is last_out with keep of (W-S)+L lanes; go to IDLE.
  - L>S: the merged beat is full; go to FLUSH.
- Single-beat packet (last_in in HDR):
  - If L>N, output one beat of L-N bytes, last_out=1.
  - Otherwise emit no output beat, pulse pkt_drop, and make hdr_keep reflect only the bytes actually received.
- ready_in = (HDR|BODY) & (!valid_out | ready_out). FLUSH holds ready_in=0.

## Timing
- Reset values: ready_in=0, ready_strip=0, valid_out=0, data_out=0, keep_out=0, last_out=0, hdr_vld=0, hdr_data=0, hdr_keep=0, pkt_drop=0. The FSM resets to IDLE; ready_strip rises the first cycle after rst deasserts.
- The output is registered. A beat appears the cycle after the input beat that completes it is accepted.
- The FLUSH beat loads the cycle after the output register frees.
- hdr_vld and pkt_drop assert the cycle after the first beat is accepted.
- Throughput is one beat per cycle in BODY with ready_out=1. Each packet has one bubble for the command in IDLE.
- While valid_out=1 and ready_out=0, data_out, keep_out and last_out stay stable.
- The next command may be accepted in IDLE while the previous packet's last beat is still held in the output register.
- rst mid-packet clears all state immediately. No partial packet is emitted afterwards.

## Configuration
- STRIP_HDR_OUT_EN defined: the header capture register drives hdr_vld, hdr_data and hdr_keep as specified.
- STRIP_HDR_OUT_EN undefined:
  - hdr_vld, hdr_data and hdr_keep are tied to 0 and the capture register is not built.
  - Stripping, alignment and pkt_drop behave identically.

## Test plan
- W=4, cnt=1 (N=2); beats 0xAABBCCDD/F, 0x11223344/F, 0x55660000/1100 last -> hdr 0x0000AABB keep 0011; out 0xCCDD1122/F, 0x33445566/F last.
- Same stream, last 0x55667700/1110 -> out 0xCCDD1122/F, 0x33445566/F, 0x77000000/1000 last (FLUSH beat).
- cnt=3 (N=4); 0x01020304/F, 0x05060708/1000 last -> hdr 0x01020304/F; out 0x05000000/1000 last.
- cnt=3, single beat 0xDEADBEEF/F last -> hdr_vld and pkt_drop pulse once; no valid_out.
- Random ready_out (80% high), 100 packets with random cnt/length -> no byte loss or duplication against a reference model; outputs stable under stall.
- Assert rst mid-BODY -> all outputs 0 the same cycle; the next packet strips correctly.
